// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, instruction field positions, control-flag struct and encoders.
// Opcodes that are not listed here decode with all control flags clear.
package decode_pkg;

    localparam logic [6:0] OP_NOP = 7'h00;
    localparam logic [6:0] OP_ADD = 7'h01;
    localparam logic [6:0] OP_SUB = 7'h02;
    localparam logic [6:0] OP_MUL = 7'h03;
    localparam logic [6:0] OP_LDB = 7'h04;
    localparam logic [6:0] OP_LDW = 7'h05;
    localparam logic [6:0] OP_STB = 7'h06;
    localparam logic [6:0] OP_STW = 7'h07;
    localparam logic [6:0] OP_BEQ = 7'h08;
    localparam logic [6:0] OP_JMP = 7'h09;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 25;
    localparam int DST_HI  = 24;
    localparam int DST_LO  = 20;
    localparam int SRC1_HI = 19;
    localparam int SRC1_LO = 15;
    localparam int SRC2_HI = 14;
    localparam int SRC2_LO = 10;
    localparam int JMP_LO_HI = 14;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_byte;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

    function automatic ctrl_t enc_ctrl(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: c.reg_write = 1'b1;
            OP_LDB: begin c.mem_read = 1'b1; c.mem_byte = 1'b1; end
            OP_LDW: c.mem_read = 1'b1;
            OP_STB: begin c.mem_write = 1'b1; c.mem_byte = 1'b1; end
            OP_STW: c.mem_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_uses_rs2(input logic [6:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_STB) || (op == OP_STW);
    endfunction

    function automatic logic op_known(input logic [6:0] op);
        return op <= OP_JMP;
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational field split, offset sign-extension and control-flag encoding; zero latency, no handshake.
// DECODE_ILLEGAL_TRAP_EN adds o_illegal for opcodes outside the known set.
module decode_fields
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_OFF_W = 15,
    parameter int BRN_OFF_W = 15
) (
    input  logic [31:0]     i_instr,
    output logic [6:0]      o_opcode,
    output logic [4:0]      o_dst,
    output logic [4:0]      o_src1,
    output logic [4:0]      o_src2,
    output logic [XLEN-1:0] o_mem_offset,
    output logic [XLEN-1:0] o_brn_offset,
    output logic [19:0]     o_jmp_offset,
    output ctrl_t           o_ctrl,
    output logic            o_alu_imm_src
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            o_illegal
`endif
);

    logic [MEM_OFF_W-1:0] w_mem_raw;
    logic [BRN_OFF_W-1:0] w_brn_raw;
    logic [XLEN-1:0]      w_brn_ext;

    assign o_opcode = i_instr[OPC_HI:OPC_LO];
    assign o_dst    = i_instr[DST_HI:DST_LO];
    assign o_src1   = i_instr[SRC1_HI:SRC1_LO];
    assign o_src2   = i_instr[SRC2_HI:SRC2_LO];

    // Branch offset borrows the dst field as its upper bits.
    assign w_mem_raw = i_instr[MEM_OFF_W-1:0];
    assign w_brn_raw = {i_instr[DST_HI:DST_LO], i_instr[BRN_OFF_W-6:0]};

    assign o_mem_offset = {{(XLEN-MEM_OFF_W){w_mem_raw[MEM_OFF_W-1]}}, w_mem_raw};
    assign w_brn_ext    = {{(XLEN-BRN_OFF_W){w_brn_raw[BRN_OFF_W-1]}}, w_brn_raw};
    assign o_brn_offset = w_brn_ext << 2;
    assign o_jmp_offset = {i_instr[DST_HI:DST_LO], i_instr[JMP_LO_HI:0]};

    assign o_ctrl        = enc_ctrl(o_opcode);
    assign o_alu_imm_src = o_ctrl.mem_read | o_ctrl.mem_write;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign o_illegal = !op_known(o_opcode);
`endif

endmodule

// File: rtl/decode_stage.sv
// ID pipeline register: 1-cycle decode, stalls fetch on backpressure, load-use and MUL result hazards; flush drops the held slot.
// DECODE_ILLEGAL_TRAP_EN adds id_illegal; illegal instructions never raise or match hazards.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_OFF_W = 15,
    parameter int BRN_OFF_W = 15,
    parameter int MUL_LAT   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    output logic [4:0]      id_dst_reg,
    output logic [4:0]      id_src_reg_1,
    output logic [4:0]      id_src_reg_2,
    output logic [XLEN-1:0] id_mem_offset,
    output logic [XLEN-1:0] id_brn_offset,
    output logic [19:0]     id_jmp_offset,
    output logic            id_alu_imm_src,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_mem_byte,
    output logic            id_reg_write,
    output logic            id_mem_to_reg,
    output logic            hazard_stall
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            id_illegal
`endif
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(MUL_LAT - 1);

    logic [6:0]      w_opcode;
    logic [4:0]      w_dst, w_src1, w_src2;
    logic [XLEN-1:0] w_mem_off, w_brn_off;
    logic [19:0]     w_jmp_off;
    ctrl_t           w_ctrl;
    logic            w_alu_imm;
    logic            w_legal;

    logic            r_id_valid;
    logic [XLEN-1:0] r_id_pc;
    logic [6:0]      r_id_opcode;
    logic [4:0]      r_id_dst, r_id_src1, r_id_src2;
    logic [XLEN-1:0] r_id_mem_off, r_id_brn_off;
    logic [19:0]     r_id_jmp_off;
    ctrl_t           r_id_ctrl;
    logic            r_id_alu_imm;
    logic [CNT_W-1:0] r_mul_cnt;
    logic [4:0]      r_mul_dst;

    logic w_rs1_en, w_rs2_en, w_hit_ld, w_hit_mul, w_hazard;
    logic w_advance, w_load, w_mul_leave;

    decode_fields #(
        .XLEN      (XLEN),
        .MEM_OFF_W (MEM_OFF_W),
        .BRN_OFF_W (BRN_OFF_W)
    ) u_fields (
        .i_instr       (if_instr),
        .o_opcode      (w_opcode),
        .o_dst         (w_dst),
        .o_src1        (w_src1),
        .o_src2        (w_src2),
        .o_mem_offset  (w_mem_off),
        .o_brn_offset  (w_brn_off),
        .o_jmp_offset  (w_jmp_off),
        .o_ctrl        (w_ctrl),
        .o_alu_imm_src (w_alu_imm)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .o_illegal     (w_illegal)
`endif
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic w_illegal;
    logic r_id_illegal;
    assign w_legal    = !w_illegal;
    assign id_illegal = r_id_illegal;
`else
    assign w_legal = 1'b1;
`endif

    // r0 is hardwired, so it can never carry a dependency.
    assign w_rs1_en  = w_legal && (w_src1 != 5'd0);
    assign w_rs2_en  = w_legal && op_uses_rs2(w_opcode) && (w_src2 != 5'd0);
    assign w_hit_ld  = (w_rs1_en && (w_src1 == r_id_dst)) || (w_rs2_en && (w_src2 == r_id_dst));
    assign w_hit_mul = (w_rs1_en && (w_src1 == r_mul_dst)) || (w_rs2_en && (w_src2 == r_mul_dst));
    assign w_hazard  = (r_id_valid && r_id_ctrl.mem_read && w_hit_ld) ||
                       ((r_mul_cnt != '0) && w_hit_mul);

    assign w_advance    = !r_id_valid || ex_ready;
    assign if_ready     = w_advance && !w_hazard && !flush;
    assign w_load       = if_valid && if_ready;
    assign hazard_stall = w_advance && w_hazard && if_valid;
    assign w_mul_leave  = r_id_valid && ex_ready && (r_id_opcode == OP_MUL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id_valid   <= 1'b0;
            r_id_pc      <= '0;
            r_id_opcode  <= '0;
            r_id_dst     <= '0;
            r_id_src1    <= '0;
            r_id_src2    <= '0;
            r_id_mem_off <= '0;
            r_id_brn_off <= '0;
            r_id_jmp_off <= '0;
            r_id_ctrl    <= '0;
            r_id_alu_imm <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            r_id_illegal <= 1'b0;
`endif
        end else if (flush) begin
            r_id_valid <= 1'b0;
        end else if (w_load) begin
            r_id_valid   <= 1'b1;
            r_id_pc      <= if_pc;
            r_id_opcode  <= w_opcode;
            r_id_dst     <= w_dst;
            r_id_src1    <= w_src1;
            r_id_src2    <= w_src2;
            r_id_mem_off <= w_mem_off;
            r_id_brn_off <= w_brn_off;
            r_id_jmp_off <= w_jmp_off;
            r_id_ctrl    <= w_ctrl;
            r_id_alu_imm <= w_alu_imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
            r_id_illegal <= w_illegal;
`endif
        end else if (w_advance) begin
            r_id_valid <= 1'b0;
        end
    end

    // A flushed MUL has already been handed to execute, so it still arms the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_cnt <= '0;
            r_mul_dst <= '0;
        end else if (w_mul_leave) begin
            r_mul_cnt <= CNT_ARM;
            r_mul_dst <= r_id_dst;
        end else if (r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - 1'b1;
        end
    end

    assign id_valid       = r_id_valid;
    assign id_pc          = r_id_pc;
    assign id_opcode      = r_id_opcode;
    assign id_dst_reg     = r_id_dst;
    assign id_src_reg_1   = r_id_src1;
    assign id_src_reg_2   = r_id_src2;
    assign id_mem_offset  = r_id_mem_off;
    assign id_brn_offset  = r_id_brn_off;
    assign id_jmp_offset  = r_id_jmp_off;
    assign id_alu_imm_src = r_id_alu_imm;
    assign id_mem_read    = r_id_ctrl.mem_read;
    assign id_mem_write   = r_id_ctrl.mem_write;
    assign id_mem_byte    = r_id_ctrl.mem_byte;
    assign id_reg_write   = r_id_ctrl.reg_write;
    assign id_mem_to_reg  = r_id_ctrl.mem_to_reg;

    property p_hold_when_stalled;
        @(posedge clk) disable iff (reset)
            (r_id_valid && !ex_ready && !flush) |=>
                ($stable(r_id_valid) && $stable(r_id_pc) && $stable(r_id_opcode) &&
                 $stable(r_id_dst) && $stable(r_id_src1) && $stable(r_id_src2) &&
                 $stable(r_id_mem_off) && $stable(r_id_brn_off) && $stable(r_id_jmp_off) &&
                 $stable(r_id_ctrl) && $stable(r_id_alu_imm));
    endproperty
    a_hold_when_stalled: assert property (p_hold_when_stalled);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus hazard, backpressure, flush and reset sequences.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [4:0]  id_dst_reg, id_src_reg_1, id_src_reg_2;
    logic [31:0] id_mem_offset, id_brn_offset;
    logic [19:0] id_jmp_offset;
    logic        id_alu_imm_src, id_mem_read, id_mem_write, id_mem_byte, id_reg_write, id_mem_to_reg;
    logic        hazard_stall;

    int checks   = 0;
    int failures = 0;

    decode_stage #(.XLEN(32), .MEM_OFF_W(15), .BRN_OFF_W(15), .MUL_LAT(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .flush          (flush),
        .ex_ready       (ex_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .id_dst_reg     (id_dst_reg),
        .id_src_reg_1   (id_src_reg_1),
        .id_src_reg_2   (id_src_reg_2),
        .id_mem_offset  (id_mem_offset),
        .id_brn_offset  (id_brn_offset),
        .id_jmp_offset  (id_jmp_offset),
        .id_alu_imm_src (id_alu_imm_src),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_mem_byte    (id_mem_byte),
        .id_reg_write   (id_reg_write),
        .id_mem_to_reg  (id_mem_to_reg),
        .hazard_stall   (hazard_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] mem_off;
        logic [31:0] brn_off;
        logic [19:0] jmp_off;
        logic [5:0]  flags;   // {alu_imm, mem_read, mem_write, mem_byte, reg_write, mem_to_reg}
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [14:0] lo);
        return {op, d, s1, lo};
    endfunction

    function automatic logic [31:0] flags_now();
        return 32'({id_alu_imm_src, id_mem_read, id_mem_write, id_mem_byte, id_reg_write, id_mem_to_reg});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic er, input logic fl);
        @(negedge clk);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        ex_ready = er;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{mk(OP_LDW, 5'd3, 5'd1, 15'h7FF0),  32'hFFFFFFF0, 32'h00003FC0, 20'h1FFF0, 6'b110000};
        vecs[1] = '{mk(OP_ADD, 5'd4, 5'd1, 15'h0800),  32'h00000800, 32'h00004000, 20'h20800, 6'b000010};
        vecs[2] = '{mk(OP_STB, 5'd9, 5'd5, 15'h1BFF),  32'h00001BFF, 32'h00009FFC, 20'h49BFF, 6'b101100};
        vecs[3] = '{mk(OP_LDB, 5'd31, 5'd0, 15'h4000), 32'hFFFFC000, 32'hFFFFF000, 20'hFC000, 6'b110100};
        vecs[4] = '{mk(OP_STW, 5'd2, 5'd7, 15'h0000),  32'h00000000, 32'h00002000, 20'h10000, 6'b101000};
        vecs[5] = '{mk(7'h55, 5'd1, 5'd31, 15'h7FFF),  32'hFFFFFFFF, 32'h00001FFC, 20'h0FFFF, 6'b000000};
        vecs[6] = '{mk(OP_SUB, 5'd20, 5'd21, 15'h5800), 32'hFFFFD800, 32'hFFFF4000, 20'hA5800, 6'b000010};
        vecs[7] = '{mk(OP_MUL, 5'd10, 5'd11, 15'h3000), 32'h00003000, 32'h0000A000, 20'h53000, 6'b000010};

        reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_hazard", 32'(hazard_stall), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_mem_off", id_mem_offset, 32'd0);
        chk("rst_flags", flags_now(), 32'd0);

        // Decode table: independent instructions streamed back-to-back.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
            chk($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'd1);
            chk($sformatf("v%0d_hazard", i), 32'(hazard_stall), 32'd0);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'd1);
            chk($sformatf("v%0d_pc", i), id_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d_opcode", i), 32'(id_opcode), 32'(vecs[i].instr[31:25]));
            chk($sformatf("v%0d_dst", i), 32'(id_dst_reg), 32'(vecs[i].instr[24:20]));
            chk($sformatf("v%0d_src1", i), 32'(id_src_reg_1), 32'(vecs[i].instr[19:15]));
            chk($sformatf("v%0d_src2", i), 32'(id_src_reg_2), 32'(vecs[i].instr[14:10]));
            chk($sformatf("v%0d_mem_off", i), id_mem_offset, vecs[i].mem_off);
            chk($sformatf("v%0d_brn_off", i), id_brn_offset, vecs[i].brn_off);
            chk($sformatf("v%0d_jmp_off", i), 32'(id_jmp_offset), 32'(vecs[i].jmp_off));
            chk($sformatf("v%0d_flags", i), flags_now(), 32'(vecs[i].flags));
        end
        idle(4);

        // Load-use: one stall, one bubble, then ADD presented.
        drive(1'b1, mk(OP_LDW, 5'd5, 5'd1, 15'h0), 32'h2000, 1'b1, 1'b0);
        tick();
        drive(1'b1, mk(OP_ADD, 5'd6, 5'd5, 15'h0800), 32'h2004, 1'b1, 1'b0);
        chk("lu_if_ready", 32'(if_ready), 32'd0);
        chk("lu_hazard", 32'(hazard_stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(id_valid), 32'd0);
        drive(1'b1, mk(OP_ADD, 5'd6, 5'd5, 15'h0800), 32'h2004, 1'b1, 1'b0);
        chk("lu_release_ready", 32'(if_ready), 32'd1);
        chk("lu_release_hazard", 32'(hazard_stall), 32'd0);
        tick();
        chk("lu_add_valid", 32'(id_valid), 32'd1);
        chk("lu_add_opcode", 32'(id_opcode), 32'(OP_ADD));
        chk("lu_add_pc", id_pc, 32'h2004);
        idle(2);

        // MUL r7 leaves, then SUB r8,r7,r0 waits out two counter cycles.
        drive(1'b1, mk(OP_MUL, 5'd7, 5'd1, 15'h0800), 32'h3000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, mk(OP_SUB, 5'd8, 5'd7, 15'h0), 32'h3008, 1'b1, 1'b0);
            chk($sformatf("mul_stall%0d", k), 32'(hazard_stall), 32'd1);
            chk($sformatf("mul_ready%0d", k), 32'(if_ready), 32'd0);
            tick();
            chk($sformatf("mul_bubble%0d", k), 32'(id_valid), 32'd0);
        end
        drive(1'b1, mk(OP_SUB, 5'd8, 5'd7, 15'h0), 32'h3008, 1'b1, 1'b0);
        chk("mul_drained_ready", 32'(if_ready), 32'd1);
        chk("mul_drained_hazard", 32'(hazard_stall), 32'd0);
        tick();
        chk("mul_sub_valid", 32'(id_valid), 32'd1);
        chk("mul_sub_opcode", 32'(id_opcode), 32'(OP_SUB));
        drive(1'b1, mk(OP_MUL, 5'd7, 5'd1, 15'h0800), 32'h3010, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, mk(OP_SUB, 5'd8, 5'd0, 15'h0), 32'h3018, 1'b1, 1'b0);
        chk("mul_r0_ready", 32'(if_ready), 32'd1);
        chk("mul_r0_hazard", 32'(hazard_stall), 32'd0);
        tick();
        idle(3);

        // Backpressure: held for 4 cycles, next instruction loads on release.
        drive(1'b1, mk(OP_ADD, 5'd1, 5'd2, 15'h0C00), 32'h4000, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, mk(OP_STW, 5'd4, 5'd5, 15'h1800), 32'h4004, 1'b0, 1'b0);
            chk($sformatf("bp_ready%0d", k), 32'(if_ready), 32'd0);
            tick();
            chk($sformatf("bp_valid%0d", k), 32'(id_valid), 32'd1);
            chk($sformatf("bp_pc%0d", k), id_pc, 32'h4000);
            chk($sformatf("bp_opcode%0d", k), 32'(id_opcode), 32'(OP_ADD));
        end
        drive(1'b1, mk(OP_STW, 5'd4, 5'd5, 15'h1800), 32'h4004, 1'b1, 1'b0);
        chk("bp_release_ready", 32'(if_ready), 32'd1);
        tick();
        chk("bp_next_pc", id_pc, 32'h4004);
        chk("bp_next_opcode", 32'(id_opcode), 32'(OP_STW));

        // Flush drops the incoming branch; replay decodes its offset.
        drive(1'b1, mk(OP_BEQ, 5'd16, 5'd0, 15'h0), 32'h5000, 1'b1, 1'b1);
        chk("fl_if_ready", 32'(if_ready), 32'd0);
        tick();
        chk("fl_id_valid", 32'(id_valid), 32'd0);
        drive(1'b1, mk(OP_BEQ, 5'd16, 5'd0, 15'h0), 32'h5000, 1'b1, 1'b0);
        chk("fl_replay_ready", 32'(if_ready), 32'd1);
        tick();
        chk("fl_replay_valid", 32'(id_valid), 32'd1);
        chk("fl_replay_brn", id_brn_offset, 32'hFFFF0000);
        chk("fl_replay_pc", id_pc, 32'h5000);
        idle(1);

        // Flush while a MUL leaves still arms the scoreboard.
        drive(1'b1, mk(OP_MUL, 5'd9, 5'd1, 15'h0800), 32'h6000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("flmul_valid", 32'(id_valid), 32'd0);
        drive(1'b1, mk(OP_SUB, 5'd1, 5'd9, 15'h0), 32'h6008, 1'b1, 1'b0);
        chk("flmul_hazard", 32'(hazard_stall), 32'd1);
        tick();
        idle(3);

        // Asynchronous reset in the middle of a load-use stall.
        drive(1'b1, mk(OP_LDW, 5'd5, 5'd1, 15'h0), 32'h7000, 1'b1, 1'b0);
        tick();
        drive(1'b1, mk(OP_ADD, 5'd6, 5'd5, 15'h0800), 32'h7004, 1'b1, 1'b0);
        chk("rs_pre_hazard", 32'(hazard_stall), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rs_id_valid", 32'(id_valid), 32'd0);
        chk("rs_hazard", 32'(hazard_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rs_if_ready", 32'(if_ready), 32'd1);
        chk("rs_post_hazard", 32'(hazard_stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised successor of the combinational instruction decoder: the ID pipeline stage between fetch and execute.
- Splits fields, sign-extends memory and branch offsets, and generates the memory and register-access control flags.
- Holds the decoded instruction in an output register with a valid/ready handshake.
- Detects load-use hazards and multi-cycle MUL result hazards, and inserts bubbles; supports branch flush.

Parameters:
- XLEN, 32, data/offset/PC width.
- MEM_OFF_W, 15, raw M-type offset width, instr[MEM_OFF_W-1:0].
- BRN_OFF_W, 15, raw B-type offset width, {instr[24:20], instr[BRN_OFF_W-6:0]}.
- MUL_LAT, 3, MUL result latency in cycles (>=1); 1 disables the MUL scoreboard.

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock; reset is asynchronous and active-high
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- if_ready  out  1  decode accepts this cycle
- flush  in  1  kill the instruction held in decode (branch taken)
- ex_ready  in  1  execute accepts id_* this cycle
- id_valid  out  1  id_* holds a live instruction
- id_pc  out  XLEN  registered PC
- id_opcode  out  7  instr[31:25]
- id_dst_reg / id_src_reg_1 / id_src_reg_2  out  5 each  instr[24:20] / [19:15] / [14:10]
- id_mem_offset  out  XLEN  sign-extended M-type offset
- id_brn_offset  out  XLEN  sign-extended B-type offset, shifted left 2
- id_jmp_offset  out  20  {instr[24:20], instr[14:0]}
- id_alu_imm_src, id_mem_read, id_mem_write, id_mem_byte, id_reg_write, id_mem_to_reg  out  1 each  control flags
- hazard_stall  out  1  bubble inserted due to hazard this cycle

Behaviour:
- Reset: all id_* = 0; id_valid = 0; MUL counter = 0; hazard_stall = 0. if_ready is combinational and follows the equations below from these register values.
- advance = !id_valid || ex_ready.
- if_ready = advance && !hazard.
- Load on (if_valid && if_ready): id_* = decode(if_instr); id_valid = 1. Latency from acceptance to presentation is 1 cycle.
- advance && !load: id_valid <= 0 (bubble). This includes the hazard case; hazard_stall = advance && hazard && if_valid.
- !advance: id_* held stable. This is a required assertion.
- Control flags {mem_read, mem_write, mem_byte, reg_write, mem_to_reg}:
  - ADD/SUB/MUL = 00010
  - LDB = 10100
  - LDW = 10000
  - STB = 01100
  - STW = 01000
  - all other opcodes = 00000
  - alu_imm_src = mem_read | mem_write.
- Offset extension replicates the top bit of the raw field to XLEN. Branch offset = ext(raw) << 2, truncated to XLEN.
- Hazard match uses the incoming instruction's sources:
  - uses_rs1 for all opcodes.
  - uses_rs2 only for ADD/SUB/MUL/STB/STW.
  - A source index of 0 never matches.
- Load-use: id_valid && id_mem_read && id_dst_reg matches an incoming source → hazard.
- MUL scoreboard:
  - When a MUL leaves decode (id_valid && ex_ready && opcode==MUL), set cnt = MUL_LAT-1 and mul_dst = id_dst_reg.
  - Otherwise, cnt decrements while > 0.
  - cnt > 0 and mul_dst matches an incoming source → hazard.
  - A new MUL leaving overrides the current count.
- Flush:
  - id_valid <= 0 next cycle and if_ready = 0 this cycle. Flush overrides a simultaneous load.
  - The scoreboard is unaffected, because the MUL is already in execute.
  - A flush in the same cycle a MUL leaves still arms the counter.
- Reset mid-stall: immediate return to the reset state; no pending hazard survives.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output id_illegal (1 bit, reset 0), set when the loaded opcode is not a known OP_* encoding.
  - An illegal instruction is forced to all-zero control flags and never triggers or matches a hazard.
- Undefined: the port is absent and unknown opcodes decode as a NOP (flags 00000).

Decomposition:
- Shared package decode_pkg holds:
  - OP_* opcode constants;
  - field bit positions;
  - a control-flag struct/typedef {mem_read, mem_write, mem_byte, reg_write, mem_to_reg};
  - the flag-encoding function.
- One natural sub-module, decode_fields: purely combinational field split, offset extension and flag encoding. Its outputs are identical to those of the previous decoder.
- decode_stage adds the register, handshake, scoreboard and flush.

Test Plan:
- LDW r3,0x7FF0(r1): if_instr opcode LDW, instr[14:0] = 0x7FF0, accepted with ex_ready = 1 → next cycle id_valid = 1, id_mem_offset = 0xFFFFFFF0, flags 10000, alu_imm_src = 1.
- Load-use: LDW r5 then ADD r6,r5,r2 back-to-back, ex_ready = 1 → ADD held with if_ready = 0 and hazard_stall = 1 for 1 cycle; a bubble appears at id_valid; ADD is presented on cycle +2.
- MUL latency: MUL_LAT = 3, MUL r7 then SUB r8,r7,r0 → SUB held until the counter drains (2 bubbles); SUB r8,r0,r0 after MUL incurs no stall.
- Backpressure: ex_ready = 0 for 4 cycles with id_valid = 1 → id_* stable and if_ready = 0; release → the next instruction loads in the same cycle.
- Flush coinciding with if_valid and a branch offset raw 0x4000 → id_valid = 0 next cycle and the instruction is dropped; replay without flush gives id_brn_offset = 0xFFFF0000.
- Reset asserted asynchronously mid-stall → id_valid and hazard_stall = 0 immediately, and if_ready = 1 with reset released.
